conv_host_mem: RTL

//   Synthesizable host/memory responder for the CONV accelerator. Holds the 64x64 input image
//   ROM (loaded by an external loader) and the layer-0 (4096x20) and layer-1 (1024x20) result

---
 rtl/conv_host_mem_if.sv | 29 ++
 rtl/conv_host_mem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_host_mem_if.sv
// CONV <-> host/memory bus: start handshake, image read port and layer
// memory read/write ports. The CONV engine is the master and the host
// memory block is the slave.
interface conv_host_mem_if #(
  parameter int DW     = 20,
  parameter int IMG_AW = 12
);
  logic              ready;
  logic              busy;
  logic [IMG_AW-1:0] iaddr;
  logic [DW-1:0]     idata;
  logic              cwr;
  logic [IMG_AW-1:0] caddr_wr;
  logic [DW-1:0]     cdata_wr;
  logic              crd;
  logic [IMG_AW-1:0] caddr_rd;
  logic [DW-1:0]     cdata_rd;
  logic [2:0]        csel;

  modport master (
    input  ready, idata, cdata_rd,
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, cdata_rd,
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/conv_host_mem.sv
// Host/memory responder for the CONV accelerator. Holds the input image
// ROM (filled by an external loader while idle), the layer-0 and layer-1
// result memories, runs the ready/busy start handshake and offers a
// readback port for results once CONV has finished.
// Memories are written on the rising edge and read on the falling edge,
// so CONV sees data for an address it launched at one posedge before the
// next posedge, and a write is visible to a read half a cycle later.
module conv_host_mem #(
  parameter int DW     = 20,
  parameter int IMG_AW = 12,
  parameter int L1_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [IMG_AW-1:0] ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              start,
  conv_host_mem_if.slave    bus,
  input  logic              rb_sel,
  input  logic [IMG_AW-1:0] rb_addr,
  output logic [DW-1:0]     rb_data,
  output logic              done,
  output logic [IMG_AW:0]   wr_cnt0,
  output logic [L1_AW:0]    wr_cnt1,
  output logic              csel_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  localparam logic [IMG_AW:0] CNT0_ONE = 1;
  localparam logic [L1_AW:0]  CNT1_ONE = 1;
  localparam logic [IMG_AW:0] CNT0_MAX = '1;
  localparam logic [L1_AW:0]  CNT1_MAX = '1;

  localparam int IMG_DEPTH = 1 << IMG_AW;
  localparam int L1_DEPTH  = 1 << L1_AW;

  logic [1:0] state;
  logic       busy_d;
  logic       ready_q;

  logic [DW-1:0] img_mem [0:IMG_DEPTH-1];
  logic [DW-1:0] l0_mem  [0:IMG_DEPTH-1];
  logic [DW-1:0] l1_mem  [0:L1_DEPTH-1];

  logic in_run;
  logic in_idle;
  logic rb_window;
  logic start_ok;
  logic sel_l0;
  logic sel_l1;
  logic l1_addr_ok;
  logic wr_l0;
  logic wr_l1;
  logic wr_bad;
  logic rd_bad;
  logic feed_image;

  assign in_run    = (state == S_RUN);
  assign in_idle   = (state == S_IDLE);
  assign rb_window = in_idle || (state == S_DONE);
  assign start_ok  = start && rb_window;

  // Layer decode: only two csel codes map to memories, everything else is an error.
  assign sel_l0     = (bus.csel == CSEL_L0);
  assign sel_l1     = (bus.csel == CSEL_L1);
  assign l1_addr_ok = (bus.caddr_wr[IMG_AW-1:L1_AW] == '0);

  // A write is accepted only while CONV is running; out-of-range L1 writes are dropped.
  assign wr_l0  = in_run && bus.cwr && sel_l0;
  assign wr_l1  = in_run && bus.cwr && sel_l1 && l1_addr_ok;
  assign wr_bad = in_run && bus.cwr && !wr_l0 && !wr_l1;
  assign rd_bad = bus.crd && !sel_l0 && !sel_l1;

  // Image words are only streamed once the handshake has completed.
  assign feed_image = in_run && !ready_q && bus.busy;

  assign bus.ready = ready_q;
  assign done      = (state == S_DONE);

  // Start handshake: raise ready on start, drop it when CONV reports busy,
  // and finish on the falling edge of busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ready_q <= 1'b0;
      busy_d  <= 1'b0;
    end else begin
      busy_d <= bus.busy;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_START;
            ready_q <= 1'b1;
          end
        end
        S_START: begin
          if (bus.busy) begin
            state   <= S_RUN;
            ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (!bus.busy && busy_d) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            state   <= S_START;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-run write counters (saturating) and the sticky select-error flag, all cleared by a new start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt0  <= '0;
      wr_cnt1  <= '0;
      csel_err <= 1'b0;
    end else if (start_ok) begin
      wr_cnt0  <= '0;
      wr_cnt1  <= '0;
      csel_err <= 1'b0;
    end else begin
      if (wr_l0 && (wr_cnt0 != CNT0_MAX)) begin
        wr_cnt0 <= wr_cnt0 + CNT0_ONE;
      end
      if (wr_l1 && (wr_cnt1 != CNT1_MAX)) begin
        wr_cnt1 <= wr_cnt1 + CNT1_ONE;
      end
      if (wr_bad || rd_bad) begin
        csel_err <= 1'b1;
      end
    end
  end

  // Image loader: only accepted while idle so a run never sees a half-updated image.
  always_ff @(posedge clk) begin
    if (in_idle && ld_en) begin
      img_mem[ld_addr] <= ld_data;
    end
  end

  // Layer-0 result memory write port.
  always_ff @(posedge clk) begin
    if (wr_l0) begin
      l0_mem[bus.caddr_wr] <= bus.cdata_wr;
    end
  end

  // Layer-1 result memory write port; the range check above guarantees the upper address bits are zero.
  always_ff @(posedge clk) begin
    if (wr_l1) begin
      l1_mem[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
    end
  end

  // Image read on the falling edge; idata is forced to zero outside an active run.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      bus.idata <= '0;
    end else if (feed_image) begin
      bus.idata <= img_mem[bus.iaddr];
    end else begin
      bus.idata <= '0;
    end
  end

  // Layer read on the falling edge; an illegal select or no strobe leaves the last word in place.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      bus.cdata_rd <= '0;
    end else if (bus.crd && sel_l0) begin
      bus.cdata_rd <= l0_mem[bus.caddr_rd];
    end else if (bus.crd && sel_l1) begin
      bus.cdata_rd <= l1_mem[bus.caddr_rd[L1_AW-1:0]];
    end
  end

  // Readback port for the host, live only when CONV is not using the memories.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_data <= '0;
    end else if (rb_window) begin
      rb_data <= rb_sel ? l1_mem[rb_addr[L1_AW-1:0]] : l0_mem[rb_addr];
    end else begin
      rb_data <= '0;
    end
  end

endmodule
